lu_op_identifier: RTL and testbench
===================================

LU_OP_IDENTIFIER -- requirements
Module: lu_op_identifier

Interface
REQ-001 Parameter MAX_SAMPLES, default 8, range 2..15: samples accepted per identification before a forced decision.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, range 1..255: idle-cycle limit in COLLECT; used only when LU_OPID_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a new identification.
REQ-006 in_valid  input  1  sample a, b, result is presented.
REQ-007 a, b  input  1 each  operand pair applied to the unknown logic unit.
REQ-008 result  input  1  output observed from the unknown logic unit.
REQ-009 in_ready  output  1  high exactly while in COLLECT.
REQ-010 ack  input  1  consumer acknowledges the decision; returns the block to IDLE.
REQ-011 op  output  2  identified operation: 00 OR, 01 NOR, 10 XOR, 11 XNOR.
REQ-012 op_valid  output  1  decision held on op, ambiguous and conflict.
REQ-013 ambiguous  output  1  decision forced with more than one candidate remaining.
REQ-014 conflict  output  1  no candidate is consistent with the samples.
REQ-015 timeout  output  1  COLLECT abandoned because no sample arrived in time.
REQ-016 cand_mask  output  4  live candidate set; bit i corresponds to op encoding i.
REQ-017 sample_count  output  4  samples accepted in the current identification.

Function
REQ-018 States: IDLE, COLLECT, DONE, ERROR; all outputs registered.
REQ-019 IDLE: start -> COLLECT, with cand_mask=1111 and sample_count=0; in_valid is ignored.
REQ-020 COLLECT: a sample is accepted when in_valid=1; accepted samples update cand_mask &= consistency vector and increment sample_count by one, both visible the next cycle.
REQ-021 Consistency vector: bit0 = (a|b)==result; bit1 = ~(a|b)==result; bit2 = (a^b)==result; bit3 = ~(a^b)==result.
REQ-022 Updated mask one-hot -> DONE; op = index of the set bit; op_valid=1; ambiguous=0; op_valid rises one cycle after the deciding sample.
REQ-023 Updated mask zero -> ERROR; op_valid=1; conflict=1; op=00.
REQ-024 Updated mask has two or more bits set and sample_count reaches MAX_SAMPLES -> DONE; ambiguous=1; op = lowest set index.
REQ-025 start in COLLECT restarts the identification (mask=1111, count=0); a simultaneous in_valid sample is discarded.
REQ-026 DONE/ERROR: all outputs are held until ack=1; ack -> IDLE with op_valid, ambiguous, conflict and timeout cleared the next cycle; start is ignored in these states.
REQ-027 ack outside DONE/ERROR has no effect.
REQ-028 sample_count never wraps; it saturates at MAX_SAMPLES.

Reset
REQ-029 rst=1 forces IDLE, op=00, op_valid=0, ambiguous=0, conflict=0, timeout=0, in_ready=0, cand_mask=1111, sample_count=0, and clears the idle-cycle counter.
REQ-030 rst takes priority over start, in_valid and ack in every state, including mid-COLLECT.

Configuration
REQ-031 Macro LU_OPID_TIMEOUT_EN defined: in COLLECT, an internal counter counts consecutive cycles with in_valid=0 and clears on any accepted sample or on restart; reaching TIMEOUT_CYCLES -> ERROR with timeout=1, conflict=0, op_valid=1.
REQ-032 Macro LU_OPID_TIMEOUT_EN undefined: no counter exists; timeout is constant 0; COLLECT waits indefinitely.

Verification
REQ-033 Reset, then start, then samples (0,0,0) and (1,1,1) -> cand_mask 1111 -> 0101 -> 0001; op=00, op_valid=1, ambiguous=0.
REQ-034 start, then samples (0,0,1) and (1,1,1) -> cand_mask 1010 -> 1000; op=11, op_valid=1.
REQ-035 start, then samples (0,0,0) and (0,0,1) -> cand_mask 0101 -> 0000; ERROR, conflict=1, op=00; ack -> IDLE, op_valid=0 next cycle.
REQ-036 MAX_SAMPLES=2; start, then samples (0,1,1) and (1,0,1) -> mask 0101; DONE, ambiguous=1, op=00, sample_count=2.
REQ-037 Start plus one sample, then rst=1 mid-COLLECT -> next cycle IDLE, cand_mask=1111, sample_count=0, in_ready=0.
REQ-038 With LU_OPID_TIMEOUT_EN defined and TIMEOUT_CYCLES=4: start, then no in_valid -> ERROR with timeout=1 after 4 idle cycles; without the macro, the block stays in COLLECT and timeout=0.

Source files
------------

// File: rtl/lu_op_identifier.sv
// rtl/lu_op_identifier.sv - identifies OR/NOR/XOR/XNOR from observed operand/result samples
// Optional feature macro: LU_OPID_TIMEOUT_EN (idle-cycle timeout while collecting).
module lu_op_identifier #(
  parameter int MAX_SAMPLES    = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  input  logic       result,
  input  logic       ack,
  output logic       in_ready,
  output logic [1:0] op,
  output logic       op_valid,
  output logic       ambiguous,
  output logic       conflict,
  output logic       timeout,
  output logic [3:0] cand_mask,
  output logic [3:0] sample_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [1:0] S_ERROR   = 2'd3;
  localparam logic [3:0] MAX_CNT   = 4'(MAX_SAMPLES);

  logic [1:0] state;
  logic [3:0] consist;
  logic [3:0] next_mask;
  logic [3:0] next_count;
  logic [1:0] low_idx;
  logic       one_hot;
  logic       idle_expire;

  always_comb begin
    consist[0] = ((a | b) == result);
    consist[1] = ((~(a | b)) == result);
    consist[2] = ((a ^ b) == result);
    consist[3] = ((~(a ^ b)) == result);
    next_mask  = cand_mask & consist;
    next_count = (sample_count == MAX_CNT) ? sample_count : sample_count + 4'd1;
    one_hot    = $onehot(next_mask);
    // lowest set index doubles as the one-hot index
    if (next_mask[0])      low_idx = 2'd0;
    else if (next_mask[1]) low_idx = 2'd1;
    else if (next_mask[2]) low_idx = 2'd2;
    else                   low_idx = 2'd3;
  end

`ifdef LU_OPID_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] idle_cnt;

  assign idle_expire = (state == S_COLLECT) && !start && !in_valid && (idle_cnt == TO_LIM - 8'd1);

  always_ff @(posedge clk) begin
    if (rst)
      idle_cnt <= 8'd0;
    else if (state == S_COLLECT && !start && !in_valid)
      idle_cnt <= idle_cnt + 8'd1;
    else
      idle_cnt <= 8'd0;
  end
`else
  // no timeout in this build; TIMEOUT_CYCLES has no effect
  assign idle_expire = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      op           <= 2'd0;
      op_valid     <= 1'b0;
      ambiguous    <= 1'b0;
      conflict     <= 1'b0;
      timeout      <= 1'b0;
      in_ready     <= 1'b0;
      cand_mask    <= 4'hF;
      sample_count <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_COLLECT;
            in_ready     <= 1'b1;
            cand_mask    <= 4'hF;
            sample_count <= 4'd0;
          end
        end
        S_COLLECT: begin
          if (start) begin
            cand_mask    <= 4'hF;
            sample_count <= 4'd0;
          end else if (in_valid) begin
            cand_mask    <= next_mask;
            sample_count <= next_count;
            if (next_mask == 4'd0) begin
              state    <= S_ERROR;
              in_ready <= 1'b0;
              op_valid <= 1'b1;
              conflict <= 1'b1;
              op       <= 2'd0;
            end else if (one_hot || next_count == MAX_CNT) begin
              state     <= S_DONE;
              in_ready  <= 1'b0;
              op_valid  <= 1'b1;
              op        <= low_idx;
              ambiguous <= !one_hot;
            end
          end else if (idle_expire) begin
            state    <= S_ERROR;
            in_ready <= 1'b0;
            op_valid <= 1'b1;
            timeout  <= 1'b1;
            conflict <= 1'b0;
            op       <= 2'd0;
          end
        end
        S_DONE, S_ERROR: begin
          if (ack) begin
            state     <= S_IDLE;
            op_valid  <= 1'b0;
            ambiguous <= 1'b0;
            conflict  <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lu_op_identifier.sv
// tb/tb_lu_op_identifier.sv - scoreboard bench for lu_op_identifier (default and MAX_SAMPLES=2 instances)
module tb_lu_op_identifier;

  typedef struct packed {
    logic [1:0] op;
    logic       amb;
    logic       conf;
    logic       to;
    logic [3:0] mask;
    logic [3:0] cnt;
  } res_t;

  logic clk = 1'b0;
  logic rst, start, in_valid, a, b, result, ack;

  logic       d0_in_ready, d0_op_valid, d0_amb, d0_conf, d0_to;
  logic [1:0] d0_op;
  logic [3:0] d0_mask, d0_cnt;
  logic       d1_in_ready, d1_op_valid, d1_amb, d1_conf, d1_to;
  logic [1:0] d1_op;
  logic [3:0] d1_mask, d1_cnt;

  int vectors = 0;
  int miscompares = 0;
  res_t q0[$];
  res_t q1[$];

  always #5 clk = ~clk;

  lu_op_identifier #(.MAX_SAMPLES(8), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b),
    .result(result), .ack(ack), .in_ready(d0_in_ready), .op(d0_op),
    .op_valid(d0_op_valid), .ambiguous(d0_amb), .conflict(d0_conf),
    .timeout(d0_to), .cand_mask(d0_mask), .sample_count(d0_cnt)
  );

  lu_op_identifier #(.MAX_SAMPLES(2), .TIMEOUT_CYCLES(4)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b),
    .result(result), .ack(ack), .in_ready(d1_in_ready), .op(d1_op),
    .op_valid(d1_op_valid), .ambiguous(d1_amb), .conflict(d1_conf),
    .timeout(d1_to), .cand_mask(d1_mask), .sample_count(d1_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic send(input logic sa, input logic sb, input logic sr);
    in_valid = 1'b1; a = sa; b = sb; result = sr;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  function automatic res_t observe(input int sel);
    if (sel == 0) return {d0_op, d0_amb, d0_conf, d0_to, d0_mask, d0_cnt};
    return {d1_op, d1_amb, d1_conf, d1_to, d1_mask, d1_cnt};
  endfunction

  task automatic pop_compare(input int sel, input string tag);
    int n = 0;
    res_t e, o;
    while (!(sel == 0 ? d0_op_valid : d1_op_valid) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_op_valid"}, 16'(sel == 0 ? d0_op_valid : d1_op_valid), 16'd1);
    check({tag, "_sb_depth"}, 16'(sel == 0 ? q0.size() : q1.size()), 16'd1);
    if ((sel == 0 ? q0.size() : q1.size()) > 0) begin
      e = (sel == 0) ? q0.pop_front() : q1.pop_front();
      o = observe(sel);
      check({tag, "_op"},   16'(o.op),   16'(e.op));
      check({tag, "_amb"},  16'(o.amb),  16'(e.amb));
      check({tag, "_conf"}, 16'(o.conf), 16'(e.conf));
      check({tag, "_to"},   16'(o.to),   16'(e.to));
      check({tag, "_mask"}, 16'(o.mask), 16'(e.mask));
      check({tag, "_cnt"},  16'(o.cnt),  16'(e.cnt));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0; result = 1'b0; ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_op",       16'(d0_op),       16'd0);
    check("rst_op_valid", 16'(d0_op_valid), 16'd0);
    check("rst_amb",      16'(d0_amb),      16'd0);
    check("rst_conf",     16'(d0_conf),     16'd0);
    check("rst_to",       16'(d0_to),       16'd0);
    check("rst_in_ready", 16'(d0_in_ready), 16'd0);
    check("rst_mask",     16'(d0_mask),     16'hF);
    check("rst_cnt",      16'(d0_cnt),      16'd0);

    // OR identified
    pulse_start();
    check("or_in_ready", 16'(d0_in_ready), 16'd1);
    check("or_mask0",    16'(d0_mask),     16'hF);
    q0.push_back('{op: 2'd0, amb: 1'b0, conf: 1'b0, to: 1'b0, mask: 4'b0001, cnt: 4'd2});
    send(1'b0, 1'b0, 1'b0);
    check("or_mask1",    16'(d0_mask),     16'b0101);
    check("or_cnt1",     16'(d0_cnt),      16'd1);
    check("or_pending",  16'(d0_op_valid), 16'd0);
    send(1'b1, 1'b1, 1'b1);
    pop_compare(0, "or");
    pulse_start();
    check("done_hold_valid", 16'(d0_op_valid), 16'd1);
    check("done_hold_ready", 16'(d0_in_ready), 16'd0);
    pulse_ack();
    check("or_ack_valid", 16'(d0_op_valid), 16'd0);

    // XNOR identified
    pulse_start();
    q0.push_back('{op: 2'd3, amb: 1'b0, conf: 1'b0, to: 1'b0, mask: 4'b1000, cnt: 4'd2});
    send(1'b0, 1'b0, 1'b1);
    check("xnor_mask1", 16'(d0_mask), 16'b1010);
    send(1'b1, 1'b1, 1'b1);
    pop_compare(0, "xnor");
    pulse_ack();

    // conflict
    pulse_start();
    q0.push_back('{op: 2'd0, amb: 1'b0, conf: 1'b1, to: 1'b0, mask: 4'b0000, cnt: 4'd2});
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b1);
    pop_compare(0, "conflict");
    pulse_ack();
    check("conf_ack_valid", 16'(d0_op_valid), 16'd0);
    check("conf_ack_conf",  16'(d0_conf),     16'd0);

    // forced ambiguous decision: dut2 at 2 samples, dut at 8 (count saturation)
    pulse_start();
    q1.push_back('{op: 2'd0, amb: 1'b1, conf: 1'b0, to: 1'b0, mask: 4'b0101, cnt: 4'd2});
    q0.push_back('{op: 2'd0, amb: 1'b1, conf: 1'b0, to: 1'b0, mask: 4'b0101, cnt: 4'd8});
    send(1'b0, 1'b1, 1'b1);
    send(1'b1, 1'b0, 1'b1);
    pop_compare(1, "amb2");
    check("amb8_mid_ready", 16'(d0_in_ready), 16'd1);
    check("amb8_mid_cnt",   16'(d0_cnt),      16'd2);
    for (int i = 0; i < 6; i++) send(1'b0, 1'b1, 1'b1);
    pop_compare(0, "amb8");
    check("amb2_held_cnt", 16'(d1_cnt), 16'd2);
    pulse_ack();
    check("amb_ack_amb", 16'(d0_amb), 16'd0);

    // restart in COLLECT discards simultaneous sample; ack in COLLECT ignored
    pulse_start();
    send(1'b0, 1'b0, 1'b0);
    check("rs_mask1", 16'(d0_mask), 16'b0101);
    start = 1'b1; in_valid = 1'b1; a = 1'b0; b = 1'b0; result = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("rs_mask",  16'(d0_mask), 16'hF);
    check("rs_cnt",   16'(d0_cnt),  16'd0);
    send(1'b1, 1'b0, 1'b1);
    pulse_ack();
    check("ack_collect_ready", 16'(d0_in_ready), 16'd1);
    check("ack_collect_mask",  16'(d0_mask),     16'b0101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", 16'(d0_in_ready), 16'd0);
    check("midrst_mask",  16'(d0_mask),     16'hF);
    check("midrst_cnt",   16'(d0_cnt),      16'd0);

    // idle behaviour in COLLECT
    pulse_start();
    for (int i = 0; i < 3; i++) tick();
`ifdef LU_OPID_TIMEOUT_EN
    check("to_early_valid", 16'(d0_op_valid), 16'd0);
    q0.push_back('{op: 2'd0, amb: 1'b0, conf: 1'b0, to: 1'b1, mask: 4'hF, cnt: 4'd0});
    tick();
    check("to_fire_valid", 16'(d0_op_valid), 16'd1);
    pop_compare(0, "timeout");
`else
    for (int i = 0; i < 17; i++) tick();
    check("noto_ready", 16'(d0_in_ready), 16'd1);
    check("noto_to",    16'(d0_to),       16'd0);
    check("noto_valid", 16'(d0_op_valid), 16'd0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
